// File: rtl/cordic_sched_pkg.sv
// Shared types and constants for the CORDIC request scheduler.
// Angles are signed degrees with 16 fractional bits.
package cordic_sched_pkg;

    localparam int ANG_W = 32;

    localparam logic signed [ANG_W-1:0] ANG_90  = 32'sd5898240;
    // 180.0 degrees = 11796480
    localparam logic signed [ANG_W-1:0] ANG_MAX = ANG_90 + ANG_90;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    function automatic logic angle_in_range(input logic signed [ANG_W-1:0] ang);
        return (ang <= ANG_MAX) && (ang >= -ANG_MAX);
    endfunction

endpackage

// File: rtl/cordic_rr_arb.sv
// Two-way round-robin grant; the pointer names the requester that wins a tie
// and flips to the other requester after every accepted transfer.
module cordic_rr_arb
    import cordic_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant,
    output logic       gnt_id
);

    logic ptr_q, ptr_d;

    always_comb begin
        gnt_id = (req == 2'b11) ? ptr_q : req[1];
        grant  = 2'b00;
        if (req != 2'b00) begin
            grant = gnt_id ? 2'b10 : 2'b01;
        end
        ptr_d = accept ? ~gnt_id : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/cordic_sched.sv
// Shares one external CORDIC core between two requesters, one request at a
// time: arbitrate, issue, wait a fixed latency, then hold the response.
module cordic_sched
    import cordic_sched_pkg::*;
#(
    parameter int XY_SIZE  = 16,
    parameter int WAIT_CYC = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [2*ANG_W-1:0]     req_angle,
    input  logic [2*XY_SIZE-1:0]   req_x,
    input  logic [2*XY_SIZE-1:0]   req_y,
    output logic [ANG_W-1:0]       core_angle,
    output logic [XY_SIZE-1:0]     core_xin,
    output logic [XY_SIZE-1:0]     core_yin,
    input  logic [XY_SIZE:0]       core_xout,
    input  logic [XY_SIZE:0]       core_yout,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_id,
    output logic [XY_SIZE:0]       rsp_x,
    output logic [XY_SIZE:0]       rsp_y,
    output logic                   rsp_err
);

    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYC - 1);

    state_e             state_q, state_d;
    logic [ANG_W-1:0]   angle_q, angle_d;
    logic [XY_SIZE-1:0] x_q, x_d, y_q, y_d;
    logic               id_q, id_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [XY_SIZE:0]   rsp_x_q, rsp_x_d, rsp_y_q, rsp_y_d;
    logic               rsp_err_q, rsp_err_d;

    logic [1:0] grant;
    logic       gnt_id;
    logic       accept;
    logic       issuing;

    assign accept = (state_q == IDLE) && (req_valid != 2'b00);

    cordic_rr_arb u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req_valid),
        .accept (accept),
        .grant  (grant),
        .gnt_id (gnt_id)
    );

    always_comb begin
        state_d   = state_q;
        angle_d   = angle_q;
        x_d       = x_q;
        y_d       = y_q;
        id_d      = id_q;
        cnt_d     = cnt_q;
        rsp_x_d   = rsp_x_q;
        rsp_y_d   = rsp_y_q;
        rsp_err_d = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    angle_d = gnt_id ? req_angle[2*ANG_W-1:ANG_W] : req_angle[ANG_W-1:0];
                    x_d     = gnt_id ? req_x[2*XY_SIZE-1:XY_SIZE] : req_x[XY_SIZE-1:0];
                    y_d     = gnt_id ? req_y[2*XY_SIZE-1:XY_SIZE] : req_y[XY_SIZE-1:0];
                    id_d    = gnt_id;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d = '0;
                if (angle_in_range(angle_q)) begin
                    rsp_err_d = 1'b0;
                    state_d   = WAIT;
                end else begin
                    rsp_err_d = 1'b1;
                    rsp_x_d   = '0;
                    rsp_y_d   = '0;
                    state_d   = RESP;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    rsp_x_d = core_xout;
                    rsp_y_d = core_yout;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            angle_q   <= '0;
            x_q       <= '0;
            y_q       <= '0;
            id_q      <= 1'b0;
            cnt_q     <= '0;
            rsp_x_q   <= '0;
            rsp_y_q   <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            angle_q   <= angle_d;
            x_q       <= x_d;
            y_q       <= y_d;
            id_q      <= id_d;
            cnt_q     <= cnt_d;
            rsp_x_q   <= rsp_x_d;
            rsp_y_q   <= rsp_y_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    // An out-of-range angle never reaches the core, so it sees zeros instead.
    assign issuing = (state_q == WAIT) || ((state_q == ISSUE) && angle_in_range(angle_q));

    assign core_angle = issuing ? angle_q : '0;
    assign core_xin   = issuing ? x_q : '0;
    assign core_yin   = issuing ? y_q : '0;

    assign req_ready = (state_q == IDLE) ? grant : 2'b00;
    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = id_q;
    assign rsp_x     = rsp_x_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: doc/cordic_sched.md
CORDIC_SCHED -- requirements
Module: cordic_sched

Interface
REQ-001 SHALL have parameter XY_SIZE, default 16, the width of the X/Y operands.
REQ-002 SHALL have parameter WAIT_CYC, default 2, the cycles from driving core inputs to sampling core outputs (range 1..15).
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  2  per-requester request strobe; bit n is requester n.
REQ-006 req_ready  out  2  per-requester accept; a request transfers when valid and ready are both high.
REQ-007 req_angle  in  64  two packed signed 32-bit angles {req1, req0}, in degrees with 16 fractional bits.
REQ-008 req_x, req_y  in  2*XY_SIZE each  packed signed {req1, req0} start vectors.
REQ-009 core_angle  out  32  angle driven to the shared CORDIC core.
REQ-010 core_xin, core_yin  out  XY_SIZE each  vector driven to the core.
REQ-011 core_xout, core_yout  in  XY_SIZE+1 each  core rotation result.
REQ-012 rsp_valid  out  1  response available.
REQ-013 rsp_ready  in  1  consumer accepts the response.
REQ-014 rsp_id  out  1  index of the requester that owns the response.
REQ-015 rsp_x, rsp_y  out  XY_SIZE+1 each  rotated result.
REQ-016 rsp_err  out  1  angle was out of range; rsp_x and rsp_y are zero.

Function
REQ-017 SHALL implement a four-state FSM: IDLE, ISSUE, WAIT, RESP.
REQ-018 In IDLE, req_ready SHALL be one-hot on the granted requester and zero otherwise.
REQ-019 Grant SHALL be round-robin: a priority pointer points at the requester that wins a simultaneous request, and the pointer moves to the other requester after each accepted transfer.
REQ-020 A lone valid requester SHALL be granted regardless of the pointer, in the same cycle.
REQ-021 On acceptance, the block SHALL register angle, x, y and id, and the FSM SHALL go to ISSUE.
REQ-022 Range check: an angle outside [-11796480, +11796480] (±180.0 deg) is out of range.
REQ-023 For an out-of-range angle, ISSUE SHALL go directly to RESP with rsp_err=1 and rsp_x=rsp_y=0.
REQ-024 For an in-range angle, ISSUE SHALL drive the core_* outputs from the registers and go to WAIT.
REQ-025 core_* outputs SHALL hold stable from ISSUE through the end of WAIT.
REQ-026 WAIT SHALL count WAIT_CYC cycles with a 4-bit counter, then capture core_xout/core_yout into rsp_x/rsp_y and go to RESP.
REQ-027 In RESP, rsp_valid=1 and rsp_x, rsp_y, rsp_id, rsp_err SHALL hold stable until rsp_ready=1.
REQ-028 The handshake cycle in RESP SHALL return the FSM to IDLE.
REQ-029 req_ready SHALL be 0 in ISSUE, WAIT and RESP; there is no overlap, so the next grant happens the cycle after the response handshake.
REQ-030 Latency for an in-range request, with rsp_ready held high, SHALL be 2+WAIT_CYC cycles from acceptance to rsp_valid.
REQ-031 Latency for an out-of-range request SHALL be 2 cycles from acceptance to rsp_valid.
REQ-032 Boundary values ±11796480 SHALL be in range; ±11796481 SHALL be out of range.
REQ-033 When core inputs are not being issued, core_* outputs SHALL be zero.

Reset
REQ-034 Reset SHALL put the FSM in IDLE and set the priority pointer to requester 0.
REQ-035 Reset SHALL zero the counter, req_ready, rsp_valid, rsp_id, rsp_x, rsp_y, rsp_err and all core_* outputs.
REQ-036 Reset in ISSUE, WAIT or RESP SHALL discard the in-flight request with no response produced.

Structure
REQ-037 Shared package SHALL hold the FSM state enum, ANG_MAX=11796480, ANG_90=5898240, and the angle width of 32.
REQ-038 One sub-module, cordic_rr_arb (2-way round-robin grant plus pointer), SHALL be instantiated; the CORDIC core SHALL stay external.

Verification
REQ-039 Request 0: angle=0, x=1000, y=0 -> rsp_valid at cycle 4 (WAIT_CYC=2), rsp_id=0, rsp_x ≈ 1646 (CORDIC gain), rsp_y ≈ 0.
REQ-040 Both requesters valid with pointer=0 -> req0 served first, then req1; on the next simultaneous request, req1 wins.
REQ-041 Angle=11796481 -> rsp_err=1, rsp_x=rsp_y=0, two cycles after acceptance; angle=-11796480 -> rsp_err=0.
REQ-042 rsp_ready held low for 5 cycles in RESP -> rsp_* stable for those 5 cycles, req_ready stays 0, then IDLE after the handshake.
REQ-043 rst asserted during WAIT -> next cycle all outputs zero, FSM in IDLE, no rsp_valid ever raised for that request.
